// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// This is the writer side of the instruction-memory interface. It takes a
// little-endian byte stream over a valid/ready handshake, builds 32-bit words
// from it and writes them in order into instruction memory. The monocycle core
// is held in reset until the whole image has loaded without error.
//
// Stream format:
//   - The 4 header bytes give N, the word count, little-endian.
//   - N*4 payload bytes follow. Each word is little-endian.
//   - [IMEM_LOADER_CHECKSUM_EN only] One trailing byte: the 8-bit sum of all
//     payload bytes, modulo 256.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   - Defined: the loader adds a CSUM state that accepts the trailing checksum
//     byte. A match goes to DONE and a mismatch goes to ERR.
//   - Undefined: the last word write goes directly to DONE.
//
// Parameters:
//   DEPTH_WORDS  capacity of instruction memory in 32-bit words
//   BASE_ADDR    byte address of the first word written
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   start         single-cycle pulse that begins a load (or reload)
//   byte_valid    byte_data is valid
//   byte_data     stream byte
//   byte_ready    loader accepts a byte this cycle
//   mem_we        instruction-memory write strobe, one cycle per word
//   mem_addr      word-aligned byte address of the write
//   mem_wdata     assembled instruction word
//   core_reset    active-high reset to the core; low only once loading is done
//   done          level: image loaded
//   error         level: load aborted
//   words_loaded  number of words written in the current load
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_reset,
    output logic        done,
    output logic        error,
    output logic [31:0] words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5,
        S_CSUM  = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;
`endif

    state_t      state_reg, state_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [31:0] shift_reg, shift_next;     // header word or payload word being built
    logic [31:0] n_reg, n_next;             // word count taken from the header
    logic [31:0] words_reg, words_next;
    logic [31:0] shifted;
    logic        byte_fire;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_reg, csum_next;
`endif

    // The first byte received ends up in bits 7:0 after four shifts.
    assign shifted   = {byte_data, shift_reg[31:8]};
    assign byte_fire = byte_valid && byte_ready;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign byte_ready = (state_reg == S_HDR) || (state_reg == S_DATA) || (state_reg == S_CSUM);
`else
    assign byte_ready = (state_reg == S_HDR) || (state_reg == S_DATA);
`endif
    assign mem_we       = (state_reg == S_WRITE);
    assign mem_wdata    = shift_reg;
    // Word count as a byte offset. Arithmetic wraps at 32 bits; a legal N
    // never reaches the wrap.
    assign mem_addr     = BASE_ADDR + {words_reg[29:0], 2'b00};
    assign words_loaded = words_reg;
    assign core_reset   = (state_reg != S_DONE);
    assign done         = (state_reg == S_DONE);
    assign error        = (state_reg == S_ERR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            byte_cnt_reg <= 2'd0;
            shift_reg    <= 32'd0;
            n_reg        <= 32'd0;
            words_reg    <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg     <= 8'd0;
`endif
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            shift_reg    <= shift_next;
            n_reg        <= n_next;
            words_reg    <= words_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg     <= csum_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        shift_next    = shift_reg;
        n_next        = n_reg;
        words_next    = words_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_next     = csum_reg;
`endif
        case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_next    = S_HDR;
                    byte_cnt_next = 2'd0;
                    words_next    = 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_next     = 8'd0;
`endif
                end
            end
            S_HDR: begin
                if (byte_fire) begin
                    shift_next    = shifted;
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        n_next = shifted;
                        if (shifted == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_next = S_CSUM;
`else
                            state_next = S_DONE;
`endif
                        end else if (shifted > 32'(DEPTH_WORDS)) begin
                            state_next = S_ERR;
                        end else begin
                            state_next = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (byte_fire) begin
                    shift_next    = shifted;
                    byte_cnt_next = byte_cnt_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_next     = csum_reg + byte_data;
`endif
                    if (byte_cnt_reg == 2'd3) begin
                        state_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // mem_addr uses the pre-increment count during this cycle.
                words_next = words_reg + 32'd1;
                if (words_reg + 32'd1 == n_reg) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = S_CSUM;
`else
                    state_next = S_DONE;
`endif
                end else begin
                    state_next = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (byte_fire) begin
                    state_next = (byte_data == csum_reg) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

endmodule
